// File: rtl/fazyrv_spm_ls.sv
// Serial/parallel data scratchpad for FazyRV: captures serial operands, runs loads,
// stores and multi-cycle shifts, owns the data bus handshake and streams results back.
module fazyrv_spm_ls #(
    parameter int CHUNKSIZE = 1,
    parameter     CONF      = "MIN",
    parameter int NCHUNK    = 32 / CHUNKSIZE
) (
    input  logic                 clk_i,
    input  logic                 rst_in,
    input  logic                 start_i,
    input  logic [1:0]           op_i,
    input  logic [1:0]           size_i,
    input  logic                 sext_i,
    input  logic                 left_i,
    input  logic                 arith_i,
    input  logic [4:0]           shamt_i,
    input  logic [31:0]          adr_i,
    input  logic [CHUNKSIZE-1:0] ser_i,
    output logic [CHUNKSIZE-1:0] ser_o,
    output logic                 ser_vld_o,
    output logic                 done_o,
    output logic                 busy_o,
    output logic                 misalngd_o,
    output logic                 dmem_cyc_o,
    output logic                 dmem_stb_o,
    output logic                 dmem_we_o,
    output logic [3:0]           dmem_be_o,
    output logic [31:0]          dmem_adr_o,
    output logic [31:0]          dmem_wdat_o,
    input  logic [31:0]          dmem_rdat_i,
    input  logic                 dmem_ack_i
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CAPT = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_SHFT = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_SHIFT = 2'b10;

    localparam int SH      = $clog2(CHUNKSIZE);
    localparam bit CHK_MIS = (CONF != "MIN");

    logic [2:0]  state_r;
    logic [1:0]  op_r;
    logic [1:0]  size_r;
    logic        sext_r;
    logic        left_r;
    logic        arith_r;
    logic [4:0]  shamt_r;
    logic [31:0] adr_r;
    logic [31:0] data_r;
    logic [5:0]  cnt_r;
    logic        fine_pend_r;
    logic        cyc_r;
    logic        done_r;
    logic        mis_r;

    logic        mis_s;
    logic [4:0]  coarse_s;
    logic [4:0]  fine_s;

    function automatic logic [31:0] shift_fn(input logic [31:0] d, input logic left,
                                             input logic arith, input logic [4:0] amt);
        if (left)
            return d << amt;
        else if (arith)
            return $unsigned($signed(d) >>> amt);
        else
            return d >> amt;
    endfunction

    function automatic logic [3:0] be_fn(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdat_fn(input logic [31:0] d, input logic [1:0] size);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_fn(input logic [31:0] rdat, input logic [1:0] size,
                                            input logic sext, input logic [1:0] a);
        logic [31:0] s;
        s = rdat >> {a, 3'b000};
        case (size)
            2'b00:   return {{24{sext & s[7]}}, s[7:0]};
            2'b01:   return {{16{sext & s[15]}}, s[15:0]};
            default: return s;
        endcase
    endfunction

    // Misalignment only applies to bus operations and only when detection is configured in
    always_comb begin
        mis_s = 1'b0;
        if (CHK_MIS && (op_i == OP_LOAD || op_i == OP_STORE)) begin
            mis_s = (size_i == 2'b10 && adr_i[1:0] != 2'b00) || (size_i == 2'b01 && adr_i[0]);
        end else begin
            mis_s = 1'b0;
        end
    end

    assign coarse_s = shamt_r >> SH;
    assign fine_s   = shamt_r & 5'(CHUNKSIZE - 1);

    // Main sequencer: operand capture, bus request, shift steps and serial output
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_r     <= S_IDLE;
            op_r        <= 2'b00;
            size_r      <= 2'b00;
            sext_r      <= 1'b0;
            left_r      <= 1'b0;
            arith_r     <= 1'b0;
            shamt_r     <= 5'd0;
            adr_r       <= 32'd0;
            data_r      <= 32'd0;
            cnt_r       <= 6'd0;
            fine_pend_r <= 1'b0;
            cyc_r       <= 1'b0;
            done_r      <= 1'b0;
            mis_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            mis_r  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start_i) begin
                        op_r    <= op_i;
                        size_r  <= size_i;
                        sext_r  <= sext_i;
                        left_r  <= left_i;
                        arith_r <= arith_i;
                        shamt_r <= shamt_i;
                        adr_r   <= adr_i;
                        cnt_r   <= 6'd0;
                        if (mis_s) begin
                            mis_r <= 1'b1;
                        end else if (op_i == OP_LOAD) begin
                            state_r <= S_REQ;
                            cyc_r   <= 1'b1;
                        end else if (op_i == OP_STORE || op_i == OP_SHIFT) begin
                            state_r <= S_CAPT;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                S_CAPT: begin
                    data_r <= {ser_i, data_r[31:CHUNKSIZE]};
                    if (cnt_r == 6'(NCHUNK - 1)) begin
                        cnt_r <= 6'd0;
                        if (op_r == OP_STORE) begin
                            state_r <= S_REQ;
                            cyc_r   <= 1'b1;
                        end else if (shamt_r == 5'd0) begin
                            state_r <= S_OUT;
                        end else begin
                            state_r     <= S_SHFT;
                            cnt_r       <= {1'b0, coarse_s};
                            fine_pend_r <= (fine_s != 5'd0);
                        end
                    end else begin
                        cnt_r <= cnt_r + 6'd1;
                    end
                end
                S_REQ: begin
                    if (dmem_ack_i) begin
                        cyc_r <= 1'b0;
                        cnt_r <= 6'd0;
                        if (op_r == OP_LOAD) begin
                            data_r  <= load_fn(dmem_rdat_i, size_r, sext_r, adr_r[1:0]);
                            state_r <= S_OUT;
                        end else begin
                            done_r  <= 1'b1;
                            state_r <= S_IDLE;
                        end
                    end
                end
                S_SHFT: begin
                    // Whole-chunk steps first, then a single fine step for the remainder
                    if (cnt_r != 6'd0) begin
                        data_r <= shift_fn(data_r, left_r, arith_r, 5'(CHUNKSIZE));
                        cnt_r  <= cnt_r - 6'd1;
                        if (cnt_r == 6'd1 && !fine_pend_r) begin
                            state_r <= S_OUT;
                        end
                    end else begin
                        data_r      <= shift_fn(data_r, left_r, arith_r, fine_s);
                        fine_pend_r <= 1'b0;
                        state_r     <= S_OUT;
                    end
                end
                S_OUT: begin
                    data_r <= data_r >> CHUNKSIZE;
                    if (cnt_r == 6'(NCHUNK - 2)) begin
                        done_r <= 1'b1;
                    end
                    if (cnt_r == 6'(NCHUNK - 1)) begin
                        cnt_r   <= 6'd0;
                        state_r <= S_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 6'd1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    cyc_r   <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = (state_r != S_IDLE);
    assign ser_vld_o   = (state_r == S_OUT);
    assign ser_o       = ser_vld_o ? data_r[CHUNKSIZE-1:0] : '0;
    assign done_o      = done_r;
    assign misalngd_o  = mis_r;
    assign dmem_cyc_o  = cyc_r;
    assign dmem_stb_o  = cyc_r;
    assign dmem_we_o   = cyc_r && (op_r == OP_STORE);
    assign dmem_be_o   = cyc_r ? be_fn(size_r, adr_r[1:0]) : 4'b0000;
    assign dmem_adr_o  = cyc_r ? {adr_r[31:2], 2'b00} : 32'd0;
    assign dmem_wdat_o = (cyc_r && op_r == OP_STORE) ? wdat_fn(data_r, size_r) : 32'd0;

endmodule
